// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// Data memory uses the addresses and status bit positions when decoding loads and stores.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam logic [31:0] UART_TXD  = 32'h0000_1000;
    localparam logic [31:0] UART_STAT = 32'h0000_1004;

    localparam int STAT_FULL_BIT  = 0;
    localparam int STAT_EMPTY_BIT = 1;
    localparam int STAT_BUSY_BIT  = 2;
    localparam int STAT_OVF_BIT   = 3;

    function automatic int div_calc(input int clkFreq, input int baud);
        return clkFreq / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head and registered status.
// A push into a full FIFO is ignored even when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [AW:0]      count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             doPush;
    logic             doPop;

    assign doPush = push_i & ~full_q;
    assign doPop  = pop_i & ~empty_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + AW'(1);
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + AW'(1);
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == FULL_COUNT);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr_q] <= data_i;
        end
    end

    assign data_o  = mem[rdPtr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign count_o = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter fed by one-cycle store strobes from data memory.
// Frames are sent LSB first; a queued byte starts immediately after the previous stop bit.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 9600,
    parameter int DEPTH    = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en_i,
    input  logic [7:0]                 wr_data_i,
    input  logic                       clr_ovf_i,
    output logic                       tx_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       busy_o,
    output logic                       overflow_o,
    output logic                       tx_done_o
);

    localparam int DIV = div_calc(CLK_FREQ, BAUD);
    localparam int BW  = $clog2(DIV);
    localparam logic [BW-1:0] BAUD_MAX = BW'(DIV - 1);
    localparam logic [BW-1:0] BAUD_ONE = BW'(1);

    tx_state_t     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;

    logic          fifoPop;
    logic [7:0]    fifoHead;
    logic          fifoFull;
    logic          fifoEmpty;
    logic          baudZero;
    logic [2:0]    nextBit;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (wr_en_i),
        .data_i  (wr_data_i),
        .pop_i   (fifoPop),
        .data_o  (fifoHead),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (count_o)
    );

    assign baudZero = (baud_q == '0);
    assign nextBit  = bit_q + 3'd1;

    // Every output is computed one cycle ahead so that tx, busy and tx_done come straight from flops.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        fifoPop = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (!fifoEmpty) begin
                    fifoPop = 1'b1;
                    shift_d = fifoHead;
                    baud_d  = BAUD_MAX;
                    state_d = START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (baudZero) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                    baud_d  = BAUD_MAX;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q - BAUD_ONE;
                end
            end
            DATA: begin
                if (baudZero) begin
                    baud_d = BAUD_MAX;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = nextBit;
                        tx_d  = shift_q[nextBit];
                    end
                end else begin
                    baud_d = baud_q - BAUD_ONE;
                end
            end
            STOP: begin
                // Raised one count early so the registered pulse lands on the last stop cycle.
                if (baud_q == BAUD_ONE) begin
                    done_d = 1'b1;
                end
                if (baudZero) begin
                    if (!fifoEmpty) begin
                        fifoPop = 1'b1;
                        shift_d = fifoHead;
                        baud_d  = BAUD_MAX;
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else begin
                    baud_d = baud_q - BAUD_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // A dropped write wins over a simultaneous clear.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_en_i && fifoFull) begin
            ovf_d = 1'b1;
        end else if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign tx_o       = tx_q;
    assign busy_o     = busy_q;
    assign tx_done_o  = done_q;
    assign overflow_o = ovf_q;
    assign full_o     = fifoFull;
    assign empty_o    = fifoEmpty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with DIV=10 and a 4-entry FIFO.
// Expected line levels are rebuilt from the byte and the cycle index within each frame.
module tb_uart_tx_fifo;

    localparam int CLK_FREQ = 1000;
    localparam int BAUD     = 100;
    localparam int DEPTH    = 4;
    localparam int FRAME    = 100;

    logic       clk;
    logic       reset;
    logic       wrEn;
    logic [7:0] wrData;
    logic       clrOvf;
    logic       tx;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       busy;
    logic       overflow;
    logic       txDone;

    int checks = 0;
    int errors = 0;

    uart_tx_fifo #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .DEPTH    (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en_i    (wrEn),
        .wr_data_i  (wrData),
        .clr_ovf_i  (clrOvf),
        .tx_o       (tx),
        .full_o     (full),
        .empty_o    (empty),
        .count_o    (count),
        .busy_o     (busy),
        .overflow_o (overflow),
        .tx_done_o  (txDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks tx/busy/tx_done from frame cycle startK to the last stop cycle (cycle 100).
    task automatic checkFrame(input logic [7:0] b, input int startK, input string tag);
        int bitIdx;
        logic expTx;
        for (int k = startK; k <= FRAME; k++) begin
            bitIdx = (k - 1) / 10;
            if (bitIdx == 0) expTx = 1'b0;
            else if (bitIdx == 9) expTx = 1'b1;
            else expTx = b[bitIdx - 1];
            chk($sformatf("%s_tx_k%0d", tag, k), {31'd0, tx}, {31'd0, expTx});
            chk($sformatf("%s_busy_k%0d", tag, k), {31'd0, busy}, 32'd1);
            chk($sformatf("%s_done_k%0d", tag, k), {31'd0, txDone}, (k == FRAME) ? 32'd1 : 32'd0);
            if (k < FRAME) step();
        end
    endtask

    task automatic checkIdle(input string tag);
        chk({tag, "_tx"}, {31'd0, tx}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, txDone}, 32'd0);
        chk({tag, "_empty"}, {31'd0, empty}, 32'd1);
    endtask

    initial begin
        reset  = 1'b1;
        wrEn   = 1'b0;
        wrData = 8'h00;
        clrOvf = 1'b0;
        step();
        step();
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_done", {31'd0, txDone}, 32'd0);
        reset = 1'b0;
        step();

        // Single byte 0xA5
        wrEn = 1'b1; wrData = 8'hA5;
        step();
        wrEn = 1'b0;
        chk("single_count_after_write", {29'd0, count}, 32'd1);
        chk("single_tx_before_pop", {31'd0, tx}, 32'd1);
        step();
        chk("single_count_after_pop", {29'd0, count}, 32'd0);
        checkFrame(8'hA5, 1, "single");
        step();
        checkIdle("single_after");

        // Back-to-back 0x00 then 0xFF
        wrEn = 1'b1; wrData = 8'h00;
        step();
        wrData = 8'hFF;
        step();
        wrEn = 1'b0;
        chk("b2b_count", {29'd0, count}, 32'd1);
        checkFrame(8'h00, 1, "b2b0");
        step();
        checkFrame(8'hFF, 1, "b2b1");
        step();
        checkIdle("b2b_after");

        // Full, overflow and set-over-clear priority
        wrEn = 1'b1;
        wrData = 8'h01; step();
        wrData = 8'h02; step();
        wrData = 8'h03; step();
        wrData = 8'h04; step();
        wrData = 8'h05; step();
        chk("full_flag", {31'd0, full}, 32'd1);
        chk("full_count", {29'd0, count}, 32'd4);
        chk("full_ovf_before", {31'd0, overflow}, 32'd0);
        wrData = 8'h06; step();
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        chk("ovf_count", {29'd0, count}, 32'd4);
        wrData = 8'h07; clrOvf = 1'b1; step();
        chk("ovf_set_wins", {31'd0, overflow}, 32'd1);
        chk("ovf_set_wins_count", {29'd0, count}, 32'd4);
        wrEn = 1'b0; step();
        clrOvf = 1'b0;
        chk("ovf_cleared", {31'd0, overflow}, 32'd0);
        chk("full_still", {31'd0, full}, 32'd1);
        checkFrame(8'h01, 7, "fq1");
        step();
        chk("fq_count_after_pop", {29'd0, count}, 32'd3);
        checkFrame(8'h02, 1, "fq2");
        step();
        checkFrame(8'h03, 1, "fq3");
        step();
        checkFrame(8'h04, 1, "fq4");
        step();
        checkFrame(8'h05, 1, "fq5");
        step();
        checkIdle("fq_after");

        // Write coinciding with the stop-bit pop
        wrEn = 1'b1; wrData = 8'h3C; step();
        wrEn = 1'b0; step();
        wrEn = 1'b1; wrData = 8'hC3; step();
        wrEn = 1'b0;
        chk("sim_count_pre", {29'd0, count}, 32'd1);
        checkFrame(8'h3C, 2, "sim0");
        wrEn = 1'b1; wrData = 8'h5A; step();
        wrEn = 1'b0;
        chk("sim_count_same", {29'd0, count}, 32'd1);
        checkFrame(8'hC3, 1, "sim1");
        step();
        checkFrame(8'h5A, 1, "sim2");
        step();
        checkIdle("sim_after");

        // Reset during data bit 3 with two bytes queued
        wrEn = 1'b1; wrData = 8'h55; step();
        wrData = 8'h11; step();
        wrData = 8'h22; step();
        wrEn = 1'b0;
        chk("mid_count", {29'd0, count}, 32'd2);
        for (int i = 0; i < 43; i++) step();
        chk("mid_tx_bit3", {31'd0, tx}, 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_tx", {31'd0, tx}, 32'd1);
        chk("mid_rst_empty", {31'd0, empty}, 32'd1);
        chk("mid_rst_count", {29'd0, count}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            chk($sformatf("post_rst_tx_%0d", i), {31'd0, tx}, 32'd1);
            chk($sformatf("post_rst_busy_%0d", i), {31'd0, busy}, 32'd0);
        end
        wrEn = 1'b1; wrData = 8'h81; step();
        wrEn = 1'b0; step();
        checkFrame(8'h81, 1, "post");
        step();
        checkIdle("post_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Memory-mapped UART transmitter that sits directly downstream of the CPU's MEM stage.
- Data memory decodes a store to the UART TX data address and issues a one-cycle write strobe with the byte.
- The block buffers bytes in a small FIFO and serialises them 8N1 on tx, LSB first.
- Status outputs (full, empty, busy, overflow) are read back by data memory on loads to the UART status address.

Parameters:
- CLK_FREQ, 100000000: system clock frequency in Hz.
- BAUD, 9600: line rate in bit/s. DIV = CLK_FREQ/BAUD clock cycles per bit, integer division, DIV >= 2 required.
- DEPTH, 8: FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- wr_en  input  1  one-cycle write strobe from the data-memory store decode.
- wr_data  input  8  byte to enqueue; sampled when wr_en=1.
- clr_ovf  input  1  clears the sticky overflow flag.
- tx  output  1  serial line; idles high.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- busy  output  1  shifter is not in IDLE.
- overflow  output  1  sticky flag: a write was dropped.
- tx_done  output  1  one-cycle pulse at the end of each stop bit.

Behaviour:
- Reset (async, takes effect immediately, including mid-frame):
  - tx=1, FIFO emptied (count=0, empty=1, full=0).
  - busy=0, overflow=0, tx_done=0.
  - FSM=IDLE, bit counter=0, baud counter=0.
- FIFO write:
  - On a clk edge with wr_en=1 and full=0, the byte is enqueued and count increments.
  - wr_en=1 with full=1: byte is dropped and overflow is set, even if a pop happens in the same cycle.
  - Simultaneous accepted write and pop: count unchanged.
  - Pointers wrap modulo DEPTH.
- overflow:
  - Cleared by clr_ovf=1 at the edge.
  - If clr_ovf and a dropped write coincide, set wins.
- Shifter FSM states: IDLE, START, DATA, STOP. All outputs are registered.
- IDLE:
  - tx=1.
  - If empty=0, pop the FIFO head into the shift register, load baud counter=DIV-1, and go to START.
- START:
  - tx=0 for DIV cycles.
  - When the baud counter reaches 0, go to DATA with bit index 0.
- DATA:
  - tx = shift[bit index] for DIV cycles per bit, bits 0..7.
  - After bit 7 completes, go to STOP.
- STOP:
  - tx=1 for DIV cycles.
  - On the final cycle, tx_done pulses.
  - If empty=0, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Latency:
  - wr_en sampled at edge N into an empty FIFO with FSM in IDLE: count=1 after edge N.
  - FIFO popped at edge N+1; tx falls after edge N+1.
  - Frame length is exactly 10*DIV cycles.
  - Back-to-back frames have no gap between stop bit and next start bit.
- busy=1 in START/DATA/STOP.
- Writes are accepted in every state; the in-flight frame is never affected by FIFO activity.
- Baud counter width is $clog2(DIV). The counter reloads to DIV-1 on every bit boundary.

Decomposition:
- Package uart_pkg:
  - tx_state_t enum (IDLE, START, DATA, STOP).
  - Function div_calc(CLK_FREQ, BAUD).
  - Constants for data-memory addresses: UART_TXD, UART_STAT.
  - Status bit positions: bit0 full, bit1 empty, bit2 busy, bit3 overflow.
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - Provides push, pop, full, empty, count.
  - First-word-fall-through head output.
  - The shifter FSM stays in uart_tx_fifo.

Test Plan (bench parameters CLK_FREQ=1000, BAUD=100, so DIV=10; DEPTH=4):
- Single byte:
  - Stimulus: reset, then wr_en with 0xA5 at edge 0.
  - Response: tx low from edge 1 for 10 cycles, then bits 1,0,1,0,0,1,0,1 (10 cycles each), then 10 cycles high.
  - tx_done pulses on cycle 100 after the fall; busy=0 after.
- Back-to-back:
  - Stimulus: write 0x00, 0xFF on consecutive cycles.
  - Response: second start bit begins on the cycle immediately after the first stop bit ends.
  - Total 200 cycles of activity; exactly two tx_done pulses.
- Full and overflow:
  - Stimulus: write 6 bytes 0x01..0x06 on consecutive cycles.
  - Response: first byte popped, FIFO then reaches full=1 with count=4, and 0x06 is dropped with overflow=1.
  - Serial output is 0x01..0x05.
  - clr_ovf then clears overflow.
- Simultaneous write and pop:
  - Stimulus: with FIFO count=1 and STOP in its final cycle, write a byte in that same cycle.
  - Response: count stays 1, and the next frame carries the older byte.
- Reset mid-frame:
  - Stimulus: assert reset during DATA bit 3 with 2 bytes queued.
  - Response: tx=1 and empty=1 immediately (asynchronously).
  - After reset deasserts, no frame is sent until a new write.
- Set/clear priority:
  - Stimulus: with FIFO full, issue clr_ovf=1 and wr_en=1 in the same cycle.
  - Response: overflow=1.
